rr_selector: RTL and testbench
==============================

Name: rr_selector

Overview:
- Parametrised, registered N-channel successor to the 4:1 selector.
- Selects one of N_CH input channels of W bits each and presents it on a one-entry registered output stage with a valid/ready handshake.
- Two modes:
  - Direct mode: the channel is chosen by iSel.
  - Round-robin mode: the channel is chosen by a rotating-priority arbiter over the channel valids.
- Sits between multiple producers and a single downstream consumer in the datapath labs.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 4, data width per channel.
- SEL_W, $clog2(N_CH), select/channel-index width. Derived localparam, not overridable.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iC  in  N_CH*W  flattened channel data; channel k = iC[k*W +: W].
- iValid  in  N_CH  per-channel data-valid.
- oReady  out  N_CH  per-channel accept. Combinational; at most one bit high.
- iMode  in  1  0 = direct select, 1 = round-robin.
- iSel  in  SEL_W  channel index used in direct mode.
- oZ  out  W  registered selected data.
- oValid  out  1  oZ/oCh hold an unconsumed item.
- oCh  out  SEL_W  index of the channel that produced oZ.
- iReady  in  1  downstream accepts oZ this cycle.

Behaviour:
- Reset (async assert, sync release):
  - oZ=0, oValid=0, oCh=0, round-robin pointer ptr=0.
  - oReady=0 while iRST=1.
- Slot free: free = !oValid || iReady. Evaluated every cycle.
- Grant, direct mode (iMode=0):
  - Grant channel iSel iff iSel < N_CH and iValid[iSel]=1.
  - iSel >= N_CH: no grant, oReady all 0.
- Grant, round-robin mode (iMode=1):
  - Grant the first k with iValid[k]=1, scanning ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
  - No valid channel: no grant.
- oReady[g] = grant_valid && free, for the granted channel g only. A producer's transfer occurs on the cycle its iValid and oReady are both 1.
- Load: on a transfer, at the next rising edge, oZ <= iC[g], oCh <= g, oValid <= 1. Latency is exactly 1 cycle from handshake to oValid.
- Drain: if oValid && iReady && no transfer, oValid <= 0. oZ and oCh hold their last values.
- Back-to-back: simultaneous drain and load in the same cycle sustain 1 item/cycle with no bubble.
- Stall: oValid && !iReady means oReady all 0, and oZ/oCh/oValid are held stable.
- Pointer:
  - Updates only on a round-robin-mode transfer: ptr <= (g == N_CH-1) ? 0 : g+1.
  - Holds in direct mode and on cycles without a transfer.
- Mode change: takes effect on the same cycle's grant evaluation. An item already in the output register is unaffected. ptr is retained across mode switches.
- Reset mid-operation: a pending output item is discarded (oValid=0 immediately on iRST assert); ptr returns to 0.
- Channel inputs need not be held stable after their handshake.

Decomposition:
- Package selector_pkg:
  - MODE_DIRECT=1'b0, MODE_RR=1'b1.
  - Function clog2_min1, returning at least 1 so SEL_W >= 1.
- Sub-module rr_arbiter (N_CH param):
  - Inputs: request vector and ptr.
  - Outputs: one-hot grant, grant index, grant_valid.
  - Purely combinational, double-vector rotate-priority.
- rr_selector instantiates rr_arbiter and owns the output register, ptr, and direct-mode path.

Test Plan:
- Reset: assert iRST mid-stream with oValid=1 -> oValid=0, oZ=0, oCh=0 immediately; after release, first RR grant starts from channel 0.
- Direct mode:
  - iMode=0, iC channels = 4'h3/4'h5/4'hA/4'hC, all valid, iReady=1, iSel=2 -> oReady=4'b0100; next cycle oZ=4'hA, oCh=2, oValid=1.
  - iSel=1 with iValid[1]=0 -> oReady=0, oValid drops after drain.
- Round-robin fairness: iMode=1, iValid=4'b1111, iReady=1 for 8 cycles -> oCh sequence 0,1,2,3,0,1,2,3, one item per cycle, no bubbles.
- Round-robin skip/wrap: iValid=4'b1001, ptr=1 -> grants 3 then 0 then 3. Then iValid=4'b0000 -> no grant, oValid=0 after drain.
- Backpressure: oValid=1, iReady=0 for 5 cycles with all channels valid -> oReady=0, oZ/oCh unchanged, ptr unchanged; on iReady=1 the next channel is granted the same cycle.
- Mode switch: RR with ptr=2, switch to direct with iSel=0 for 2 transfers, then back to RR -> RR resumes at channel 2 (oCh=2).

Source files
------------

// File: rtl/rr_selector_pkg.sv
// Shared constants and helpers for the registered N-channel round-robin selector.
package selector_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Channel-index width that never collapses to zero, even for N_CH <= 2.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_selector_if.sv
// Producer/consumer bundle of rr_selector: N input channels in, one registered item out.
interface rr_selector_if #(
  parameter int N_CH = 4,
  parameter int W    = 4
);
  import selector_pkg::*;

  localparam int SEL_W = clog2_min1(N_CH);

  // Handshake: a producer transfer happens on a cycle where iValid[k] && oReady[k];
  // the output item is consumed on a cycle where oValid && iReady. oReady is
  // combinational from iValid/iMode/iSel/iReady, so producers must not make
  // iValid depend on oReady.
  logic [N_CH*W-1:0] iC;
  logic [N_CH-1:0]   iValid;
  logic [N_CH-1:0]   oReady;
  logic              iMode;
  logic [SEL_W-1:0]  iSel;
  logic [W-1:0]      oZ;
  logic              oValid;
  logic [SEL_W-1:0]  oCh;
  logic              iReady;
  logic [SEL_W-1:0]  dbg_ptr;

  modport slave (
    input  iC, iValid, iMode, iSel, iReady,
    output oReady, oZ, oValid, oCh, dbg_ptr
  );

  modport master (
    output iC, iValid, iMode, iSel, iReady,
    input  oReady, oZ, oValid, oCh, dbg_ptr
  );

endinterface

// File: rtl/rr_selector_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
module rr_arbiter import selector_pkg::*; #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_CH-1:0]  gnt_oh_o,
  output logic [SEL_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  int                first;
  int                idx;

  // Shifting the doubled vector right by ptr puts channel ptr at bit 0,
  // so the lowest set bit of rot is the winner in rotated coordinates.
  always_comb begin
    dbl         = {req_i, req_i};
    rot         = N_CH'(dbl >> ptr_i);
    first       = N_CH;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (rot[j]) first = j;
    end
    idx         = int'(ptr_i) + first;
    if (idx >= N_CH) idx = idx - N_CH;
    gnt_valid_o = (first < N_CH);
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    if (first < N_CH) begin
      gnt_idx_o = SEL_W'(idx);
      for (int k = 0; k < N_CH; k++) begin
        if (k == idx) gnt_oh_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_selector.sv
// N-channel selector (direct or round-robin) feeding a one-entry registered output stage.
module rr_selector import selector_pkg::*; #(
  parameter int N_CH = 4,
  parameter int W    = 4
) (
  input  logic         iCLK,
  input  logic         iRST,
  rr_selector_if.slave bus
);

  localparam int SEL_W = clog2_min1(N_CH);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]     z_q, z_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;

  logic [N_CH-1:0]  rr_oh;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_valid;

  logic [N_CH-1:0]  gnt_oh;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic [W-1:0]     gnt_data;
  logic             free;
  logic             xfer;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i      (bus.iValid),
    .ptr_i      (ptr_q),
    .gnt_oh_o   (rr_oh),
    .gnt_idx_o  (rr_idx),
    .gnt_valid_o(rr_valid)
  );

  // Direct mode matches iSel against every legal index, so iSel >= N_CH grants nothing.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    if (bus.iMode == MODE_RR) begin
      gnt_oh    = rr_oh;
      gnt_idx   = rr_idx;
      gnt_valid = rr_valid;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if ((bus.iSel == SEL_W'(k)) && bus.iValid[k]) gnt_oh[k] = 1'b1;
      end
      gnt_idx   = bus.iSel;
      gnt_valid = |gnt_oh;
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_oh[k]) gnt_data = gnt_data | bus.iC[k*W +: W];
    end
  end

  assign free = !valid_q || bus.iReady;
  assign xfer = gnt_valid && free && !iRST;

  always_comb begin
    ptr_d   = ptr_q;
    z_d     = z_q;
    ch_d    = ch_q;
    valid_d = valid_q && !bus.iReady;
    if (xfer) begin
      z_d     = gnt_data;
      ch_d    = gnt_idx;
      valid_d = 1'b1;
      if (bus.iMode == MODE_RR) begin
        ptr_d = (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ptr_q   <= '0;
      z_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      z_q     <= z_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign bus.oReady  = xfer ? gnt_oh : '0;
  assign bus.oZ      = z_q;
  assign bus.oValid  = valid_q;
  assign bus.oCh     = ch_q;
  assign bus.dbg_ptr = ptr_q;

endmodule

// File: tb/tb_rr_selector.sv
// Self-checking bench for rr_selector: vector table, hand sequences, random run vs model.
module tb_rr_selector;
  import selector_pkg::*;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SW = 2;
  localparam logic [N*W-1:0] C_FIX = 16'hCA53;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_selector_if #(.N_CH(N), .W(W)) bus ();
  rr_selector #(.N_CH(N), .W(W)) dut (.iCLK(clk), .iRST(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic          m_valid;
  logic [W-1:0]  m_z;
  logic [SW-1:0] m_ch;
  int            m_ptr;
  logic [W-1:0]  exp_q[$];

  typedef struct {
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  v;
    logic          rdy;
    logic [N-1:0]  e_rdy;
    logic          e_valid;
    logic [W-1:0]  e_z;
    logic [SW-1:0] e_ch;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic set_in(input logic mode, input logic [SW-1:0] sel,
                        input logic [N-1:0] v, input logic rdy);
    bus.iC     = C_FIX;
    bus.iMode  = mode;
    bus.iSel   = sel;
    bus.iValid = v;
    bus.iReady = rdy;
  endtask

  function automatic void model_grant(output bit ok, output int g);
    ok = 1'b0;
    g  = 0;
    if (bus.iMode == MODE_DIRECT) begin
      if (int'(bus.iSel) < N && bus.iValid[bus.iSel]) begin
        ok = 1'b1;
        g  = int'(bus.iSel);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!ok && bus.iValid[k]) begin
          ok = 1'b1;
          g  = k;
        end
      end
    end
  endfunction

  // One clock: called at posedge+1 with inputs applied, returns at next posedge+1.
  task automatic cycle(output logic [N-1:0] rdy_seen);
    bit           ok;
    int           g;
    bit           free;
    logic [N-1:0] er;
    logic [W-1:0] d;
    #4;
    model_grant(ok, g);
    free = !m_valid || bus.iReady;
    er   = '0;
    if (ok && free) er[g] = 1'b1;
    rdy_seen = bus.oReady;
    chk("oReady", 32'(bus.oReady), 32'(er));
    chk("oValid", 32'(bus.oValid), 32'(m_valid));
    chk("oZ", 32'(bus.oZ), 32'(m_z));
    chk("oCh", 32'(bus.oCh), 32'(m_ch));
    chk("ptr", 32'(bus.dbg_ptr), 32'(m_ptr));
    if (m_valid && bus.iReady && exp_q.size() > 0) begin
      d = exp_q.pop_front();
      chk("sb_data", 32'(bus.oZ), 32'(d));
    end
    if (ok && free) begin
      d       = bus.iC[g*W +: W];
      exp_q.push_back(d);
      m_z     = d;
      m_ch    = SW'(g);
      m_valid = 1'b1;
      if (bus.iMode == MODE_RR) m_ptr = (g + 1) % N;
    end else if (m_valid && bus.iReady) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    chk("rst_oValid", 32'(bus.oValid), 32'd0);
    chk("rst_oZ", 32'(bus.oZ), 32'd0);
    chk("rst_oCh", 32'(bus.oCh), 32'd0);
    chk("rst_oReady", 32'(bus.oReady), 32'd0);
    chk("rst_ptr", 32'(bus.dbg_ptr), 32'd0);
    m_valid = 1'b0;
    m_z     = '0;
    m_ch    = '0;
    m_ptr   = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic mode, input logic [SW-1:0] sel, input logic [N-1:0] v,
                              input logic rdy, input logic [N-1:0] e_rdy, input logic e_valid,
                              input logic [W-1:0] e_z, input logic [SW-1:0] e_ch);
    vec_t r;
    r.mode = mode; r.sel = sel; r.v = v; r.rdy = rdy;
    r.e_rdy = e_rdy; r.e_valid = e_valid; r.e_z = e_z; r.e_ch = e_ch;
    return r;
  endfunction

  initial begin
    logic [N-1:0] rs;

    set_in(1'b0, '0, '0, 1'b0);
    #1;
    apply_reset();

    // Channels 0..3 = 3/5/A/C; sequence starts from reset (ptr 0, empty stage).
    tbl[0]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2);
    tbl[1]  = mk(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd2);
    tbl[2]  = mk(1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'h3, 2'd0);
    tbl[3]  = mk(1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd0);
    tbl[4]  = mk(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'hC, 2'd3);
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: tbl[5+i] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0);
        1: tbl[5+i] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1);
        2: tbl[5+i] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2);
        default: tbl[5+i] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'hC, 2'd3);
      endcase
    end
    tbl[13] = mk(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0);
    tbl[14] = mk(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 4'hC, 2'd3);
    tbl[15] = mk(1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0);
    tbl[16] = mk(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 4'hC, 2'd3);
    tbl[17] = mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd3);

    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].mode, tbl[i].sel, tbl[i].v, tbl[i].rdy);
      cycle(rs);
      chk($sformatf("tbl%0d_oReady", i), 32'(rs), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_oValid", i), 32'(bus.oValid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_oZ", i), 32'(bus.oZ), 32'(tbl[i].e_z));
      chk($sformatf("tbl%0d_oCh", i), 32'(bus.oCh), 32'(tbl[i].e_ch));
    end

    // Backpressure: load ch0 (ptr -> 1), stall 5 cycles, then ch1 granted on release.
    set_in(1'b1, 2'd0, 4'b1111, 1'b1);
    cycle(rs);
    chk("bp_load_ch", 32'(bus.oCh), 32'd0);
    set_in(1'b1, 2'd0, 4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(rs);
      chk("bp_oReady", 32'(rs), 32'd0);
      chk("bp_oZ", 32'(bus.oZ), 32'h3);
      chk("bp_oCh", 32'(bus.oCh), 32'd0);
      chk("bp_ptr", 32'(bus.dbg_ptr), 32'd1);
    end
    set_in(1'b1, 2'd0, 4'b1111, 1'b1);
    cycle(rs);
    chk("bp_release_oReady", 32'(rs), 32'b0010);
    chk("bp_release_oCh", 32'(bus.oCh), 32'd1);

    // Mode switch with ptr = 2: two direct transfers of ch0, then RR resumes at ch2.
    set_in(1'b0, 2'd0, 4'b1111, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cycle(rs);
      chk("ms_dir_oReady", 32'(rs), 32'b0001);
      chk("ms_dir_ptr", 32'(bus.dbg_ptr), 32'd2);
    end
    set_in(1'b1, 2'd0, 4'b1111, 1'b1);
    cycle(rs);
    chk("ms_rr_oCh", 32'(bus.oCh), 32'd2);

    // Reset with a pending item, then RR restarts from ch0.
    chk("pre_rst_oValid", 32'(bus.oValid), 32'd1);
    apply_reset();
    set_in(1'b1, 2'd0, 4'b1111, 1'b1);
    cycle(rs);
    chk("post_rst_oReady", 32'(rs), 32'b0001);
    chk("post_rst_oCh", 32'(bus.oCh), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.iC     = 16'($urandom);
      bus.iValid = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      bus.iMode  = ($urandom_range(0, 3) == 0) ? MODE_DIRECT : MODE_RR;
      bus.iSel   = 2'($urandom_range(0, N - 1));
      bus.iReady = ($urandom_range(0, 3) != 0);
      cycle(rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
